// File: rtl/mem_wb_reg.sv
// MEM->WB pipeline register with a 2-entry skid buffer; 1-cycle latency, in_ready registered so WB stalls never drop entries.
// Optional MEM_WB_PERF_EN adds perf_retired / perf_stall counters.
module mem_wb_reg #(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_instruction,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic              in_mem_read,
  input  logic              in_wb_en,
  input  logic [REG_AW-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instruction,
  output logic [DATA_W-1:0] out_wb_value,
  output logic              out_wb_en,
  output logic [REG_AW-1:0] out_rd
`ifdef MEM_WB_PERF_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_stall
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] wb_value;
    logic              wb_en;
    logic [REG_AW-1:0] rd;
  } entry_t;

  entry_t w_in_entry;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_main_nxt;
  entry_t w_skid_nxt;
  logic   r_main_vld;
  logic   r_skid_vld;
  logic   r_in_rdy;
  logic   w_main_vld_nxt;
  logic   w_skid_vld_nxt;
  logic   w_accept;
  logic   w_consume;

  // Write-back mux and r0 suppression happen here so WB sees a ready-to-use entry.
  always_comb begin
    w_in_entry          = '0;
    w_in_entry.pc       = in_pc;
    w_in_entry.instr    = in_instruction;
    w_in_entry.wb_value = in_mem_read ? in_mem_data : in_alu_result;
    w_in_entry.wb_en    = in_wb_en & ~(R0_HARDWIRED && (in_rd == '0));
    w_in_entry.rd       = in_rd;
  end

  assign w_accept  = in_valid & r_in_rdy;
  assign w_consume = r_main_vld & out_ready;

  always_comb begin
    w_main_nxt     = r_main;
    w_skid_nxt     = r_skid;
    w_main_vld_nxt = r_main_vld;
    w_skid_vld_nxt = r_skid_vld;
    if (flush) begin
      w_main_vld_nxt = 1'b0;
      w_skid_vld_nxt = 1'b0;
    end else if (!r_main_vld) begin
      if (w_accept) begin
        w_main_nxt     = w_in_entry;
        w_main_vld_nxt = 1'b1;
      end
    end else if (w_consume) begin
      if (r_skid_vld) begin
        // in_ready was low, so no accept can coincide with the SKID drain
        w_main_nxt     = r_skid;
        w_skid_vld_nxt = 1'b0;
      end else if (w_accept) begin
        w_main_nxt = w_in_entry;
      end else begin
        w_main_vld_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_nxt     = w_in_entry;
      w_skid_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_rdy   <= 1'b1;
    end else begin
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_main_vld <= w_main_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      r_in_rdy   <= ~w_skid_vld_nxt;
    end
  end

  assign in_ready        = r_in_rdy;
  assign out_valid       = r_main_vld;
  assign out_pc          = r_main.pc;
  assign out_instruction = r_main.instr;
  assign out_wb_value    = r_main.wb_value;
  assign out_wb_en       = r_main.wb_en & r_main_vld;
  assign out_rd          = r_main.rd;

`ifdef MEM_WB_PERF_EN
  logic [31:0] r_perf_retired;
  logic [31:0] r_perf_stall;

  // Flush does not clear the counters; they track WB-side activity only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_retired <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_consume) r_perf_retired <= r_perf_retired + 32'd1;
      if (r_main_vld && !out_ready) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_retired = r_perf_retired;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// Randomized + directed bench for mem_wb_reg against a queue-based occupancy model.
module tb_mem_wb_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instruction;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic        in_mem_read;
  logic        in_wb_en;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic [31:0] out_wb_value;
  logic        out_wb_en;
  logic [4:0]  out_rd;
`ifdef MEM_WB_PERF_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_stall;
`endif

  mem_wb_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instruction(in_instruction),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_mem_read(in_mem_read), .in_wb_en(in_wb_en), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instruction(out_instruction),
    .out_wb_value(out_wb_value), .out_wb_en(out_wb_en), .out_rd(out_rd)
`ifdef MEM_WB_PERF_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] val;
    logic        en;
    logic [4:0]  rd;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] m_retired;
  logic [31:0] m_stall;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] md, input logic mr, input logic we,
                       input logic [4:0] rd, input logic ordy, input logic fl);
    in_valid       = v;
    in_pc          = pc;
    in_instruction = ~pc;
    in_alu_result  = alu;
    in_mem_data    = md;
    in_mem_read    = mr;
    in_wb_en       = we;
    in_rd          = rd;
    out_ready      = ordy;
    flush          = fl;
  endtask

  // Compare DUT against the model, advance the model with the current inputs, then clock.
  task automatic cyc();
    exp_t e;
    bit   acc;
    bit   con;
    check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("out_pc", 64'(out_pc), 64'(mq[0].pc));
      check("out_instruction", 64'(out_instruction), 64'(mq[0].ins));
      check("out_wb_value", 64'(out_wb_value), 64'(mq[0].val));
      check("out_wb_en", 64'(out_wb_en), 64'(mq[0].en));
      check("out_rd", 64'(out_rd), 64'(mq[0].rd));
    end else begin
      check("out_wb_en_idle", 64'(out_wb_en), 64'd0);
    end
`ifdef MEM_WB_PERF_EN
    check("perf_retired", 64'(perf_retired), 64'(m_retired));
    check("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
    if (!rst) begin
      mq.delete();
      m_retired = '0;
      m_stall   = '0;
    end else begin
      acc = in_valid && (mq.size() < 2);
      con = (mq.size() > 0) && out_ready;
      if (mq.size() > 0) begin
        if (out_ready) m_retired++;
        else m_stall++;
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (con) void'(mq.pop_front());
        if (acc) begin
          e.pc  = in_pc;
          e.ins = in_instruction;
          e.val = in_mem_read ? in_mem_data : in_alu_result;
          e.en  = in_wb_en && (in_rd != 5'd0);
          e.rd  = in_rd;
          mq.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_retired = '0;
    m_stall   = '0;
    rst = 1'b0;
    drive(1'b1, 32'h40, 32'h7, 32'h0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cyc();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_wb_value", 64'(out_wb_value), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // First accept after release shows up one cycle later
    rst = 1'b1;
    cyc();
    check("first_acc_valid", 64'(out_valid), 64'd1);
    check("first_acc_pc", 64'(out_pc), 64'h40);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc();

    // Streaming at full rate
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 32'(17 * (i + 1)), 32'h0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
      cyc();
      check("stream_pc", 64'(out_pc), 64'(i * 4));
      check("stream_val", 64'(out_wb_value), 64'(17 * (i + 1)));
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc();

    // Load select and r0 suppression
    drive(1'b1, 32'h20, 32'h5, 32'hDEADBEEF, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    cyc();
    check("load_val", 64'(out_wb_value), 64'hDEADBEEF);
    check("load_wb_en", 64'(out_wb_en), 64'd1);
    drive(1'b1, 32'h24, 32'h5, 32'hDEADBEEF, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    cyc();
    check("r0_wb_en", 64'(out_wb_en), 64'd0);
    check("r0_val", 64'(out_wb_value), 64'hDEADBEEF);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc();

    // Backpressure fills SKID, then drains in order
    drive(1'b1, 32'h10, 32'h1, 32'h0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h14, 32'h2, 32'h0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    cyc();
    cyc();
    check("bp_hold_pc", 64'(out_pc), 64'h10);
    out_ready = 1'b1;
    cyc();
    check("bp_second_pc", 64'(out_pc), 64'h14);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    cyc();

    // Flush with SKID full and a pending input, then with MAIN full plus an accept
    drive(1'b1, 32'h30, 32'h3, 32'h0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h34, 32'h3, 32'h0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h38, 32'h3, 32'h0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1);
    cyc();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_wb_en", 64'(out_wb_en), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h50, 32'h3, 32'h0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h54, 32'h3, 32'h0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1);
    cyc();
    check("flush2_out_valid", 64'(out_valid), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc();
    cyc();

    // Random traffic; a refused entry is held stable until accepted
    for (int n = 0; n < 3000; n++) begin
      bit hold;
      hold = in_valid && rst && !flush && (mq.size() >= 2);
      if (!hold) begin
        in_valid       = ($urandom_range(0, 9) < 7);
        in_pc          = $urandom() & 32'hFFFF_FFFC;
        in_instruction = $urandom();
        in_alu_result  = $urandom();
        in_mem_data    = $urandom();
        in_mem_read    = $urandom_range(0, 1) == 1;
        in_wb_en       = $urandom_range(0, 3) != 0;
        in_rd          = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom());
      end
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 199) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
